// File: rtl/conv_seq_if.sv
// Signal bundle between conv_seq_ctrl (master) and the buffer memories, the conv datapath
// and the result sink (slave side).
interface conv_seq_if #(
    parameter int DW   = 8,
    parameter int OW   = 16,
    parameter int DIMW = 4,
    parameter int AW   = 8
);
    logic            in_rd_en;
    logic [AW-1:0]   in_addr;
    logic [DW-1:0]   in_rd_data;
    logic            ker_rd_en;
    logic [AW-1:0]   ker_addr;
    logic [DW-1:0]   ker_rd_data;
    logic [DW-1:0]   conv_in;
    logic [DW-1:0]   conv_ker;
    logic [DIMW-1:0] conv_in_row;
    logic [DIMW-1:0] conv_in_col;
    logic [DIMW-1:0] conv_ker_row;
    logic [DIMW-1:0] conv_ker_col;
    logic [OW-1:0]   conv_out;
    logic            res_valid;
    logic [OW-1:0]   res_data;

    modport master (
        output in_rd_en, in_addr,
        input  in_rd_data,
        output ker_rd_en, ker_addr,
        input  ker_rd_data,
        output conv_in, conv_ker, conv_in_row, conv_in_col, conv_ker_row, conv_ker_col,
        input  conv_out,
        output res_valid, res_data
    );

    modport slave (
        input  in_rd_en, in_addr,
        output in_rd_data,
        input  ker_rd_en, ker_addr,
        output ker_rd_data,
        input  conv_in, conv_ker, conv_in_row, conv_in_col, conv_ker_row, conv_ker_col,
        output conv_out,
        input  res_valid, res_data
    );
endinterface

// File: rtl/conv_seq_ctrl.sv
// Sequencer for the conv datapath: loads input then kernel, times the compute window, drains results.
// Define CONV_SEQ_DIMCHK_EN to reject starts whose kernel exceeds the input (adds the err port).
module conv_seq_ctrl #(
    parameter int DW         = 8,
    parameter int OW         = 16,
    parameter int DIMW       = 4,
    parameter int AW         = 8,
    parameter int SETTLE_CYC = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [DIMW-1:0] in_rows,
    input  logic [DIMW-1:0] in_cols,
    input  logic [DIMW-1:0] ker_rows,
    input  logic [DIMW-1:0] ker_cols,
    output logic            busy,
    output logic            done,
`ifdef CONV_SEQ_DIMCHK_EN
    output logic            err,
`endif
    conv_seq_if.master      bus
);
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD_IN  = 3'd1,
        S_LOAD_KER = 3'd2,
        S_SETTLE   = 3'd3,
        S_COMPUTE  = 3'd4,
        S_DRAIN    = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [DIMW-1:0] in_rows_q, in_rows_d, in_cols_q, in_cols_d;
    logic [DIMW-1:0] ker_rows_q, ker_rows_d, ker_cols_q, ker_cols_d;
    logic            in_pend_q, in_pend_d, ker_pend_q, ker_pend_d;
    logic [DW-1:0]   conv_in_q, conv_in_d, conv_ker_q, conv_ker_d;
    logic            res_valid_q, res_valid_d;
    logic [OW-1:0]   res_data_q, res_data_d;
    logic            done_q, done_d;
`ifdef CONV_SEQ_DIMCHK_EN
    logic            err_q, err_d;
`endif

    logic            accept, reject, finish, dims_bad;
    logic            in_rd_en, ker_rd_en;
    logic [31:0]     ni_len, nk_len, drain_len, comp_len, cnt_inc;

`ifdef CONV_SEQ_DIMCHK_EN
    assign dims_bad = (ker_rows > in_rows) || (ker_cols > in_cols);
`else
    assign dims_bad = 1'b0;
`endif

    // Phase lengths from the latched (N-1)-encoded dimensions; conv spends
    // ker_rows*(ker_cols+2) cycles on each of the OR*OC outputs.
    always_comb begin
        ni_len    = (32'(in_rows_q) + 1) * (32'(in_cols_q) + 1);
        nk_len    = (32'(ker_rows_q) + 1) * (32'(ker_cols_q) + 1);
        drain_len = (32'(in_rows_q) - 32'(ker_rows_q) + 1) *
                    (32'(in_cols_q) - 32'(ker_cols_q) + 1);
        comp_len  = drain_len * 32'(ker_rows_q) * (32'(ker_cols_q) + 2);
        cnt_inc   = 32'(cnt_q) + 1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        reject  = 1'b0;
        finish  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (dims_bad) begin
                        reject = 1'b1;
                    end else begin
                        accept  = 1'b1;
                        state_d = S_LOAD_IN;
                        cnt_d   = '0;
                    end
                end
            end
            // The count runs one past the last address: that extra cycle is when
            // the final word returns and is registered onto conv_in/conv_ker.
            S_LOAD_IN: begin
                if (32'(cnt_q) < ni_len) begin
                    cnt_d = cnt_inc[15:0];
                end else begin
                    state_d = S_LOAD_KER;
                    cnt_d   = '0;
                end
            end
            S_LOAD_KER: begin
                if (32'(cnt_q) < nk_len) begin
                    cnt_d = cnt_inc[15:0];
                end else begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                end
            end
            S_SETTLE: begin
                if (cnt_inc >= 32'(SETTLE_CYC)) begin
                    state_d = (comp_len == 32'd0) ? S_DRAIN : S_COMPUTE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc[15:0];
                end
            end
            S_COMPUTE: begin
                if (cnt_inc >= comp_len) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc[15:0];
                end
            end
            S_DRAIN: begin
                if (cnt_inc >= drain_len) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    finish  = 1'b1;
                end else begin
                    cnt_d = cnt_inc[15:0];
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        if (abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            accept  = 1'b0;
            reject  = 1'b0;
            finish  = 1'b0;
        end
    end

    always_comb begin
        in_rd_en    = (state_q == S_LOAD_IN)  && (32'(cnt_q) < ni_len);
        ker_rd_en   = (state_q == S_LOAD_KER) && (32'(cnt_q) < nk_len);
        in_pend_d   = in_rd_en;
        ker_pend_d  = ker_rd_en;
        conv_in_d   = in_pend_q  ? bus.in_rd_data  : conv_in_q;
        conv_ker_d  = ker_pend_q ? bus.ker_rd_data : conv_ker_q;
        in_rows_d   = accept ? in_rows  : in_rows_q;
        in_cols_d   = accept ? in_cols  : in_cols_q;
        ker_rows_d  = accept ? ker_rows : ker_rows_q;
        ker_cols_d  = accept ? ker_cols : ker_cols_q;
        res_valid_d = (state_d == S_DRAIN);
        res_data_d  = res_valid_d ? bus.conv_out : res_data_q;
        done_d      = finish | reject;
`ifdef CONV_SEQ_DIMCHK_EN
        err_d       = reject;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_rows_q   <= '0;
            in_cols_q   <= '0;
            ker_rows_q  <= '0;
            ker_cols_q  <= '0;
            in_pend_q   <= 1'b0;
            ker_pend_q  <= 1'b0;
            conv_in_q   <= '0;
            conv_ker_q  <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            done_q      <= 1'b0;
`ifdef CONV_SEQ_DIMCHK_EN
            err_q       <= 1'b0;
`endif
        end else begin
            in_rows_q   <= in_rows_d;
            in_cols_q   <= in_cols_d;
            ker_rows_q  <= ker_rows_d;
            ker_cols_q  <= ker_cols_d;
            in_pend_q   <= in_pend_d;
            ker_pend_q  <= ker_pend_d;
            conv_in_q   <= conv_in_d;
            conv_ker_q  <= conv_ker_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            done_q      <= done_d;
`ifdef CONV_SEQ_DIMCHK_EN
            err_q       <= err_d;
`endif
        end
    end

    assign bus.in_rd_en     = in_rd_en;
    assign bus.in_addr      = in_rd_en  ? cnt_q[AW-1:0] : '0;
    assign bus.ker_rd_en    = ker_rd_en;
    assign bus.ker_addr     = ker_rd_en ? cnt_q[AW-1:0] : '0;
    assign bus.conv_in      = conv_in_q;
    assign bus.conv_ker     = conv_ker_q;
    assign bus.conv_in_row  = in_rows_q;
    assign bus.conv_in_col  = in_cols_q;
    assign bus.conv_ker_row = ker_rows_q;
    assign bus.conv_ker_col = ker_cols_q;
    assign bus.res_valid    = res_valid_q;
    assign bus.res_data     = res_data_q;
    assign busy             = (state_q != S_IDLE);
    assign done             = done_q;
`ifdef CONV_SEQ_DIMCHK_EN
    assign err              = err_q;
`endif
endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Self-checking bench for conv_seq_ctrl: table jobs, random jobs against a timeline model,
// and hand sequences for restart-while-busy, abort, mid-drain reset and the dimension check.
module tb_conv_seq_ctrl;
    localparam int DW = 8, OW = 16, DIMW = 4, AW = 8, SETTLE = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic [DIMW-1:0] in_rows = '0, in_cols = '0, ker_rows = '0, ker_cols = '0;
    logic            busy, done, err_s;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int busy_cnt = 0;

    logic [DW-1:0] in_mem [256];
    logic [DW-1:0] ker_mem [256];

    typedef struct { int c; int a; } ev_t;
    ev_t in_q[$], ker_q[$], done_q[$];
    int  res_q[$];

    bit in_d1 = 0, in_d2 = 0, ker_d1 = 0, ker_d2 = 0;
    int in_a1 = 0, in_a2 = 0, ker_a1 = 0, ker_a2 = 0;

    typedef struct { int ir, ic, kr, kc; int ni, nk, nres, lat; } vec_t;
    vec_t vecs[5];

    conv_seq_if #(.DW(DW), .OW(OW), .DIMW(DIMW), .AW(AW)) bus ();

    conv_seq_ctrl #(.DW(DW), .OW(OW), .DIMW(DIMW), .AW(AW), .SETTLE_CYC(SETTLE)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .in_rows  (in_rows),
        .in_cols  (in_cols),
        .ker_rows (ker_rows),
        .ker_cols (ker_cols),
        .busy     (busy),
        .done     (done),
`ifdef CONV_SEQ_DIMCHK_EN
        .err      (err_s),
`endif
        .bus      (bus)
    );
`ifndef CONV_SEQ_DIMCHK_EN
    assign err_s = 1'b0;
`endif

    always #5 clk = ~clk;

    // Synchronous-read buffer memories and the cycle counter.
    always @(posedge clk) begin
        if (bus.in_rd_en)  bus.in_rd_data  <= in_mem[bus.in_addr];
        if (bus.ker_rd_en) bus.ker_rd_data <= ker_mem[bus.ker_addr];
        cyc <= cyc + 1;
    end

    // conv stand-in: a fresh random word every cycle, changed just after the falling edge.
    initial begin
        bus.conv_out = '0;
        forever begin
            @(negedge clk);
            #2;
            bus.conv_out = OW'($urandom);
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // A word read in cycle t must sit on conv_in/conv_ker in cycle t+2.
    always @(negedge clk) begin
        if (in_d2)  chk("conv_in",  bus.conv_in,  in_mem[in_a2]);
        if (ker_d2) chk("conv_ker", bus.conv_ker, ker_mem[ker_a2]);
        in_d2 = in_d1;   in_a2 = in_a1;   in_d1 = bus.in_rd_en;  in_a1 = int'(bus.in_addr);
        ker_d2 = ker_d1; ker_a2 = ker_a1; ker_d1 = bus.ker_rd_en; ker_a1 = int'(bus.ker_addr);
        if (bus.in_rd_en)  in_q.push_back('{cyc, int'(bus.in_addr)});
        if (bus.ker_rd_en) ker_q.push_back('{cyc, int'(bus.ker_addr)});
        if (bus.res_valid) begin
            chk("res_data", bus.res_data, bus.conv_out);
            res_q.push_back(cyc);
        end
        if (done) done_q.push_back('{cyc, int'(err_s)});
        if (busy) busy_cnt++;
    end

    task automatic clear_mon();
        in_q.delete(); ker_q.delete(); res_q.delete(); done_q.delete();
        busy_cnt = 0;
    endtask

    task automatic check_zero(input string pfx);
        chk({pfx, "_busy"},      busy, 0);
        chk({pfx, "_done"},      done, 0);
        chk({pfx, "_err"},       err_s, 0);
        chk({pfx, "_in_rd"},     bus.in_rd_en, 0);
        chk({pfx, "_in_addr"},   bus.in_addr, 0);
        chk({pfx, "_ker_rd"},    bus.ker_rd_en, 0);
        chk({pfx, "_ker_addr"},  bus.ker_addr, 0);
        chk({pfx, "_conv_in"},   bus.conv_in, 0);
        chk({pfx, "_conv_ker"},  bus.conv_ker, 0);
        chk({pfx, "_in_row"},    bus.conv_in_row, 0);
        chk({pfx, "_in_col"},    bus.conv_in_col, 0);
        chk({pfx, "_ker_row"},   bus.conv_ker_row, 0);
        chk({pfx, "_ker_col"},   bus.conv_ker_col, 0);
        chk({pfx, "_res_valid"}, bus.res_valid, 0);
        chk({pfx, "_res_data"},  bus.res_data, 0);
    endtask

    // Start is raised for the cycle numbered s; the DUT samples it at the end of that cycle.
    task automatic kick(input int ir, input int ic, input int kr, input int kc, output int s);
        @(negedge clk);
        in_rows = DIMW'(ir); in_cols = DIMW'(ic); ker_rows = DIMW'(kr); ker_cols = DIMW'(kc);
        start = 1'b1;
        s = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && done_q.size() == 0; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Expected timeline of a job started in cycle s: inputs read in s+1..s+NI, kernel reads
    // begin the cycle the last input word is presented, the settle window begins the cycle
    // the last kernel word is presented, then the compute window, then OR*OC results, then done.
    task automatic check_job(input int s, input int ir, input int ic, input int kr, input int kc,
                             output int lat);
        int ni, nk, nr, comp, k0, r0, fin, e;
        ni   = (ir + 1) * (ic + 1);
        nk   = (kr + 1) * (kc + 1);
        nr   = (ir - kr + 1) * (ic - kc + 1);
        comp = nr * kr * (kc + 2);
        k0   = s + ni + 2;
        r0   = k0 + nk + 1 + SETTLE + comp;
        fin  = r0 + nr;
        chk("in_count", in_q.size(), ni);
        e = 0;
        foreach (in_q[i]) if (in_q[i].a != i || in_q[i].c != s + 1 + i) e++;
        chk("in_order", e, 0);
        chk("ker_count", ker_q.size(), nk);
        e = 0;
        foreach (ker_q[i]) if (ker_q[i].a != i || ker_q[i].c != k0 + i) e++;
        chk("ker_order", e, 0);
        chk("res_count", res_q.size(), nr);
        e = 0;
        foreach (res_q[i]) if (res_q[i] != r0 + i) e++;
        chk("res_timing", e, 0);
        chk("done_count", done_q.size(), 1);
        lat = (done_q.size() > 0) ? done_q[0].c - s : -1;
        chk("done_cycle", lat, fin - s);
        chk("done_err", (done_q.size() > 0) ? done_q[0].a : -1, 0);
        chk("busy_cycles", busy_cnt, fin - s - 1);
    endtask

    task automatic run_job(input int ir, input int ic, input int kr, input int kc,
                           input bit spec_mem, input int restart_off, output int lat);
        int s;
        clear_mon();
        for (int i = 0; i < 256; i++) begin
            in_mem[i]  = spec_mem ? ((i < 24) ? DW'(i + 1) : '0) : DW'($urandom);
            ker_mem[i] = DW'($urandom);
        end
        kick(ir, ic, kr, kc, s);
        if (restart_off > 0) begin
            while (cyc < s + restart_off) @(negedge clk);
            in_rows = '0; in_cols = '0; ker_rows = '0; ker_cols = '0;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            chk("restart_busy", busy, 1);
            chk("restart_in_row", bus.conv_in_row, ir);
            chk("restart_ker_col", bus.conv_ker_col, kc);
        end
        wait_done(4000);
        repeat (3) @(negedge clk);
        #1;
        check_job(s, ir, ic, kr, kc, lat);
        $display("job dims=%0d,%0d,%0d,%0d restart_at=%0d reads=%0d/%0d results=%0d latency=%0d",
                 ir, ic, kr, kc, restart_off, in_q.size(), ker_q.size(), res_q.size(), lat);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, s, ir, ic, kr, kc;

        vecs[0] = '{5, 5, 3, 3, 36, 16,  9, 201};
        vecs[1] = '{3, 3, 1, 1, 16,  4,  9,  61};
        vecs[2] = '{2, 4, 0, 1, 15,  2, 12,  34};
        vecs[3] = '{0, 0, 0, 0,  1,  1,  1,   8};
        vecs[4] = '{7, 3, 2, 3, 32, 12,  6, 115};

        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        $display("reset released at cycle %0d", cyc);

        foreach (vecs[v]) begin
            run_job(vecs[v].ir, vecs[v].ic, vecs[v].kr, vecs[v].kc, v == 0, 0, lat);
            chk("tbl_in_reads",  in_q.size(),  vecs[v].ni);
            chk("tbl_ker_reads", ker_q.size(), vecs[v].nk);
            chk("tbl_results",   res_q.size(), vecs[v].nres);
            chk("tbl_latency",   lat,          vecs[v].lat);
        end

        // Start pulse in the middle of the kernel load (cycles s+38..s+54) must be ignored.
        run_job(5, 5, 3, 3, 1'b1, 40, lat);
        chk("restart_latency", lat, 201);

        for (int r = 0; r < 6; r++) begin
            ir = int'($urandom_range(0, 7));
            ic = int'($urandom_range(0, 7));
            kr = int'($urandom_range(0, ir));
            kc = int'($urandom_range(0, ic));
            run_job(ir, ic, kr, kc, 1'b0, 0, lat);
        end

        // Abort during the compute window (s+57..s+191).
        clear_mon();
        kick(5, 5, 3, 3, s);
        while (cyc < s + 60) @(negedge clk);
        chk("abort_pre_busy", busy, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_rd", bus.in_rd_en | bus.ker_rd_en, 0);
        chk("abort_res_valid", bus.res_valid, 0);
        chk("abort_done", done, 0);
        repeat (200) @(negedge clk);
        #1;
        chk("abort_no_res", res_q.size(), 0);
        chk("abort_no_done", done_q.size(), 0);
        $display("abort at cycle %0d, busy=%0d afterwards", s + 60, busy);
        run_job(5, 5, 3, 3, 1'b1, 0, lat);
        chk("post_abort_latency", lat, 201);

        // Reset after the fourth result of the drain phase.
        clear_mon();
        kick(5, 5, 3, 3, s);
        for (int i = 0; i < 400 && res_q.size() < 4; i++) begin
            @(negedge clk);
            #1;
        end
        chk("rst_res_before", res_q.size(), 4);
        rst = 1'b1;
        @(negedge clk);
        check_zero("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        #1;
        chk("rst_no_more_res", res_q.size(), 4);
        chk("rst_no_done", done_q.size(), 0);
        $display("reset in drain after %0d results", res_q.size());

`ifdef CONV_SEQ_DIMCHK_EN
        clear_mon();
        kick(2, 2, 3, 3, s);
        chk("dimchk_done", done, 1);
        chk("dimchk_err", err_s, 1);
        chk("dimchk_busy", busy, 0);
        @(negedge clk);
        chk("dimchk_done_pulse", done, 0);
        chk("dimchk_err_pulse", err_s, 0);
        repeat (5) @(negedge clk);
        #1;
        chk("dimchk_no_in_reads", in_q.size(), 0);
        chk("dimchk_no_ker_reads", ker_q.size(), 0);
        $display("dimension check: rejected start, done events=%0d", done_q.size());
        run_job(3, 3, 1, 1, 1'b0, 0, lat);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
